// File: rtl/cnn_axi_pkg.sv
// cnn_axi_pkg: AXI response/burst codes and FSM state shared by the CNN write slave.
package cnn_axi_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;
    function automatic logic [1:0] resp_code(input logic dec, input logic slv);
        return dec ? RESP_DECERR : slv ? RESP_SLVERR : RESP_OKAY;
    endfunction
endpackage

// File: rtl/cnn_wr_addr_gen.sv
// cnn_wr_addr_gen: per-beat address register, beat counter and last-beat compare.
module cnn_wr_addr_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        inc_i,
    input  logic        beat_i,
    input  logic [31:0] addr_i,
    input  logic [7:0]  len_i,
    output logic [31:0] addr_o,
    output logic        last_o
);
    logic [31:0] addr_q;
    logic [7:0]  cnt_q, len_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
        end else if (load_i) begin
            addr_q <= addr_i;
            cnt_q  <= '0;
            len_q  <= len_i;
        end else if (beat_i) begin
            addr_q <= addr_q + (inc_i ? 32'd4 : 32'd0);
            cnt_q  <= cnt_q + 8'd1;
        end
    end
    assign addr_o = addr_q;
    assign last_o = cnt_q == len_q;
endmodule

// File: rtl/cnn_axi_wr_slave.sv
// cnn_axi_wr_slave: AXI4 write slave forwarding single beats to the CNN controller.
// Define CNN_WSTRB_FILTER_EN to drop (and SLVERR) beats with wstrb[1:0] != 2'b11.
module cnn_axi_wr_slave
    import cnn_axi_pkg::*;
#(
    parameter int          ID_W    = 8,
    parameter logic [31:0] ADDR_LO = 32'hD000_0000,
    parameter logic [31:0] ADDR_HI = 32'hDFFF_FFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    output logic [31:0]     out_awaddr,
    output logic            out_awvalid,
    output logic [31:0]     out_wdata,
    output logic            out_wvalid
);
    state_e          state_q;
    logic [ID_W-1:0] id_q;
    logic [1:0]      burst_q, bresp_q;
    logic            dec_q, slv_q, awready_q, wready_q, bvalid_q, out_v_q;
    logic [31:0]     out_addr_q, out_data_q, beat_addr;
    logic            last, beat, load, burst_ok, in_range, strb_ok, fwd, dec_d, slv_d;
    logic            unused_in;
    assign unused_in = ^{awsize, wstrb};
`ifdef CNN_WSTRB_FILTER_EN
    assign strb_ok = wstrb[1:0] == 2'b11;
`else
    assign strb_ok = 1'b1;
`endif
    assign load     = state_q == IDLE && awvalid;
    assign beat     = wready_q && wvalid;
    assign burst_ok = burst_q == BURST_FIXED || burst_q == BURST_INCR;
    assign in_range = beat_addr >= ADDR_LO && beat_addr <= ADDR_HI;
    assign fwd      = beat && burst_ok && in_range && strb_ok;
    assign dec_d    = dec_q | (beat && !in_range);
    assign slv_d    = slv_q | (beat && (!burst_ok || wlast != last || !strb_ok));
    cnn_wr_addr_gen u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .inc_i  (burst_q == BURST_INCR),
        .beat_i (beat),
        .addr_i (awaddr),
        .len_i  (awlen),
        .addr_o (beat_addr),
        .last_o (last)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            id_q       <= '0;
            burst_q    <= '0;
            bresp_q    <= '0;
            dec_q      <= 1'b0;
            slv_q      <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            out_v_q    <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            out_v_q    <= fwd;
            out_addr_q <= fwd ? beat_addr : '0;
            out_data_q <= fwd ? wdata : '0;
            case (state_q)
                IDLE: if (awvalid) begin
                    id_q      <= awid;
                    burst_q   <= awburst;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                    state_q   <= DATA;
                end
                DATA: begin
                    dec_q <= dec_d;
                    slv_q <= slv_d;
                    if (beat && last) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= resp_code(dec_d, slv_d);
                        state_q  <= RESP;
                    end
                end
                RESP: if (bready) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    dec_q     <= 1'b0;
                    slv_q     <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign awready     = awready_q;
    assign wready      = wready_q;
    assign bid         = id_q;
    assign bresp       = bresp_q;
    assign bvalid      = bvalid_q;
    assign out_awvalid = out_v_q;
    assign out_wvalid  = out_v_q;
    assign out_awaddr  = out_addr_q;
    assign out_wdata   = out_data_q;
endmodule

// File: doc/cnn_axi_wr_slave.md
CNN_AXI_WR_SLAVE -- requirements
Module: cnn_axi_wr_slave

Interface
REQ-001 Parameter ID_W, default 8, AXI ID width.
REQ-002 Parameter ADDR_LO, default 32'hD000_0000, lowest decoded CNN address.
REQ-003 Parameter ADDR_HI, default 32'hDFFF_FFFF, highest decoded CNN address.
REQ-004 clk  input  1  clock; rst  input  1  reset, asynchronous, active-high.
REQ-005 awid/awaddr/awlen/awsize/awburst/awvalid  input  ID_W/32/8/3/2/1  AXI4 write address channel; awready  output  1.
REQ-006 wdata/wstrb/wlast/wvalid  input  32/4/1/1  AXI4 write data channel; wready  output  1.
REQ-007 bid/bresp/bvalid  output  ID_W/2/1  AXI4 write response channel; bready  input  1.
REQ-008 out_awaddr/out_awvalid/out_wdata/out_wvalid  output  32/1/32/1  per-beat write to CNN controller; no backpressure.

Function
REQ-009 The FSM SHALL have states IDLE, DATA and RESP.
REQ-010 IDLE: awready=1, wready=0; on awvalid it SHALL capture awid, awaddr, awlen and awburst, and go to DATA.
REQ-011 DATA: awready=0, wready=1; each wvalid&&wready SHALL be one beat, with at most one beat per cycle.
REQ-012 Each accepted beat SHALL drive out_awvalid=out_wvalid=1 for exactly one cycle, one cycle after the handshake, with out_awaddr=the beat address and out_wdata=wdata.
REQ-013 out_awvalid/out_wvalid SHALL be 0 and out_awaddr/out_wdata SHALL be 0 in every cycle without a forwarded beat.
REQ-014 Beat address: beat 0 = captured awaddr; INCR (2'b01) adds 4 per beat, modulo 2^32; FIXED (2'b00) holds the address.
REQ-015 WRAP (2'b10) or reserved (2'b11) bursts SHALL accept all beats, forward none, and respond SLVERR.
REQ-016 A beat whose address lies outside [ADDR_LO, ADDR_HI] SHALL NOT be forwarded, and the response SHALL be DECERR.
REQ-017 A beat counter SHALL count 0..awlen; the beat with count==awlen SHALL end DATA and move to RESP regardless of wlast.
REQ-018 A wlast value mismatching the count==awlen condition on any beat SHALL set SLVERR; an early wlast SHALL NOT end the burst.
REQ-019 Response priority SHALL be DECERR > SLVERR > OKAY (2'b00); error flags SHALL be sticky per burst and clear on entering IDLE.
REQ-020 RESP: bvalid=1, bid=captured id, bresp=computed code, held stable until bready; bvalid&&bready SHALL return to IDLE.
REQ-021 Latency: bvalid SHALL rise in the same cycle as the last beat's out_wvalid pulse.
REQ-022 awsize SHALL be ignored, with beats treated as 4 bytes.

Reset
REQ-023 On rst the block SHALL enter IDLE, with awready=1 and all other outputs 0; an in-flight burst SHALL be abandoned with no response.
REQ-024 Counters, captured fields and error flags SHALL reset to 0.

Configuration
REQ-025 With CNN_WSTRB_FILTER_EN defined, a beat with wstrb[1:0]!=2'b11 SHALL NOT be forwarded and SHALL set SLVERR.
REQ-026 With CNN_WSTRB_FILTER_EN undefined, wstrb SHALL be ignored and all in-range beats forwarded.

Structure
REQ-027 Package cnn_axi_pkg SHALL hold the BRESP codes (OKAY/SLVERR/DECERR), the burst type codes, and the FSM state enum.
REQ-028 Sub-module cnn_wr_addr_gen SHALL hold the beat address register, increment logic, beat counter and last-beat compare.

Verification
REQ-029 INCR awaddr=D444_0000, awlen=3, 4 beats 1..4 -> out pulses at D444_0000/0004/0008/000C with data 1..4; bresp=OKAY; bid echoed.
REQ-030 FIXED awaddr=D555_0000, awlen=2 -> 3 pulses, all at D555_0000; bresp=OKAY.
REQ-031 awaddr=C000_0000, awlen=0 -> no out pulse; bresp=DECERR (2'b11).
REQ-032 awlen=1 with wlast=1 on beat 0 -> both beats forwarded; bresp=SLVERR (2'b10); RESP reached only after beat 1.
REQ-033 bready held 0 for 5 cycles -> bvalid/bresp/bid stable; awready=0 throughout; IDLE one cycle after bready=1.
REQ-034 rst asserted after beat 1 of awlen=7 -> outputs immediately at reset values; next burst awaddr=D333_0000 forwards from D333_0000 with OKAY.
